// File: rtl/pllr_mq.sv
// Soft-demapper: converts payload subcarriers into scaled, saturated LLRs using kf = 2^KSH / sigma^2.
// Optional macro PLLR_MQ_ROUND_EN adds round-half-up before the final arithmetic shift.
module pllr_mq #(
  parameter int DW  = 14,
  parameter int SW  = 12,
  parameter int KW  = 12,
  parameter int KSH = 16,
  parameter int SH  = 12,
  parameter int OW  = 8,
  parameter int A16 = 1295
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] di_re_i,
  input  logic [DW-1:0] di_im_i,
  input  logic [1:0]    di_mode_i,
  input  logic          di_vld_i,
  output logic          di_rdy_o,
  input  logic [SW-1:0] di_sigma2_i,
  input  logic          di_sigma2_vld_i,
  output logic          di_sigma2_rdy_o,
  output logic [OW-1:0] do_o,
  output logic          do_vld_o,
  input  logic          do_rdy_i,
  output logic          do_last_o
);

  localparam int QW    = KSH + 1;
  localparam int PW    = DW + KW + 2;
  localparam int CW    = $clog2(KSH + 1);
  localparam int KFMAX = 2**KW - 1;
  localparam int LMAX  = 2**(OW-1) - 1;

  localparam logic signed [PW-1:0] LPOS = PW'(LMAX);
  localparam logic signed [PW-1:0] LNEG = -LPOS;
  localparam logic signed [DW:0]   A16X = (DW+1)'(A16);
`ifdef PLLR_MQ_ROUND_EN
  localparam logic signed [PW-1:0] RND  = PW'(2**(SH-1));
`else
  localparam logic signed [PW-1:0] RND  = PW'(0);
`endif

  typedef enum logic [1:0] {NOKF, DIV, IDLE, EMIT} state_t;

  state_t              state_q, state_d;
  logic                rdyEn_q;
  logic [KW-1:0]       kf_q, kf_d;
  logic [SW-1:0]       div_q, div_d;
  logic                divZero_q, divZero_d;
  logic [SW-1:0]       rem_q, rem_d;
  logic [QW-1:0]       quo_q, quo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [SW-1:0]       pendSig_q, pendSig_d;
  logic signed [DW:0]  met_q [4];
  logic signed [DW:0]  met_d [4];
  logic [1:0]          lastIdx_q, lastIdx_d;
  logic [1:0]          idx_q, idx_d;
  logic [OW-1:0]       do_q, do_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;

  logic                diAcc, sgAcc, startDiv, geq;
  logic [SW-1:0]       divSrc, remNx;
  logic [SW:0]         remSh;
  logic [QW-1:0]       quoNx;
  logic signed [DW:0]  reX, imX, absRe, absIm, selMet;
  logic signed [PW-1:0] metX, kfX, prod, prodR, shr;
  logic [1:0]          selIdx;
  logic [OW-1:0]       llr;

  // Ready flags stay low while reset is held and rise on the first clock edge after release.
  assign di_rdy_o        = rdyEn_q & (state_q == IDLE);
  assign di_sigma2_rdy_o = rdyEn_q & ((state_q == NOKF) | (state_q == IDLE));
  assign diAcc           = di_vld_i & di_rdy_o;
  assign sgAcc           = di_sigma2_vld_i & di_sigma2_rdy_o;
  assign do_o            = do_q;
  assign do_vld_o        = vld_q;
  assign do_last_o       = last_q;

  // Restoring division of 2^KSH: the only set dividend bit enters on the first step.
  assign remSh = {rem_q, (cnt_q == '0)};
  assign geq   = remSh >= {1'b0, div_q};
  assign remNx = geq ? SW'(remSh - {1'b0, div_q}) : remSh[SW-1:0];
  assign quoNx = {quo_q[QW-2:0], geq};

  assign reX   = {di_re_i[DW-1], di_re_i};
  assign imX   = {di_im_i[DW-1], di_im_i};
  assign absRe = reX[DW] ? -reX : reX;
  assign absIm = imX[DW] ? -imX : imX;

  // The LLR presented next is either the current index (first load) or the one after it.
  assign selIdx = vld_q ? idx_q + 2'd1 : idx_q;
  assign selMet = met_q[selIdx];
  assign metX   = {{(PW-DW-1){selMet[DW]}}, selMet};
  assign kfX    = {{(PW-KW){1'b0}}, kf_q};
  assign prod   = metX * kfX;
  assign prodR  = prod + RND;
  assign shr    = prodR >>> SH;
  assign llr    = (shr > LPOS) ? LPOS[OW-1:0] : (shr < LNEG) ? LNEG[OW-1:0] : shr[OW-1:0];

  always_comb begin
    state_d   = state_q;
    kf_d      = kf_q;
    div_d     = div_q;
    divZero_d = divZero_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pendSig_d = pendSig_q;
    met_d     = met_q;
    lastIdx_d = lastIdx_q;
    idx_d     = idx_q;
    do_d      = do_q;
    vld_d     = vld_q;
    last_d    = last_q;
    startDiv  = 1'b0;
    divSrc    = di_sigma2_i;
    case (state_q)
      NOKF: if (sgAcc) startDiv = 1'b1;
      DIV: begin
        rem_d = remNx;
        quo_d = quoNx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(KSH)) begin
          if (divZero_q || (quoNx > QW'(KFMAX))) kf_d = KW'(KFMAX);
          else kf_d = quoNx[KW-1:0];
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (diAcc) begin
          state_d = EMIT;
          idx_d   = 2'd0;
          case (di_mode_i)
            2'd0: begin
              met_d[0]  = reX;
              lastIdx_d = 2'd0;
            end
            2'd2: begin
              met_d[0]  = reX;
              met_d[1]  = A16X - absRe;
              met_d[2]  = imX;
              met_d[3]  = A16X - absIm;
              lastIdx_d = 2'd3;
            end
            default: begin
              met_d[0]  = reX;
              met_d[1]  = imX;
              lastIdx_d = 2'd1;
            end
          endcase
          // A sigma^2 arriving with the payload waits until its LLRs are out.
          if (sgAcc) begin
            pend_d    = 1'b1;
            pendSig_d = di_sigma2_i;
          end
        end else if (sgAcc) begin
          startDiv = 1'b1;
        end
      end
      EMIT: begin
        if (!vld_q || do_rdy_i) begin
          if (vld_q && last_q) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
            if (pend_q) begin
              startDiv = 1'b1;
              divSrc   = pendSig_q;
              pend_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            do_d   = llr;
            vld_d  = 1'b1;
            last_d = (selIdx == lastIdx_q);
            idx_d  = selIdx;
          end
        end
      end
      default: state_d = NOKF;
    endcase
    if (startDiv) begin
      state_d   = DIV;
      div_d     = divSrc;
      divZero_d = divSrc[SW-1] | (divSrc == '0);
      rem_d     = '0;
      quo_d     = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NOKF;
      rdyEn_q   <= 1'b0;
      kf_q      <= '0;
      div_q     <= '0;
      divZero_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pendSig_q <= '0;
      for (int i = 0; i < 4; i++) met_q[i] <= '0;
      lastIdx_q <= '0;
      idx_q     <= '0;
      do_q      <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdyEn_q   <= 1'b1;
      kf_q      <= kf_d;
      div_q     <= div_d;
      divZero_q <= divZero_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pendSig_q <= pendSig_d;
      for (int i = 0; i < 4; i++) met_q[i] <= met_d[i];
      lastIdx_q <= lastIdx_d;
      idx_q     <= idx_d;
      do_q      <= do_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
    end
  end

endmodule
